// File: rtl/led_seq_ctrl_if.sv
// Bus between the LED sequencer controller and its environment: raw
// button/switch levels in, mode/colour/direction and step/reload strobes out.
interface led_seq_ctrl_if #(
  parameter int NB_SW = 4
);
  // Strobe semantics: o_tick and o_load are single-cycle pulses with no
  // back-pressure; the consumer must act on every cycle in which one is high.
  logic [NB_SW-1:0] i_btn;
  logic [NB_SW-1:0] i_sw;
  logic             o_tick;
  logic [1:0]       o_mode;
  logic [2:0]       o_color;
  logic             o_dir;
  logic             o_load;

  modport master (
    output i_btn, i_sw,
    input  o_tick, o_mode, o_color, o_dir, o_load
  );

  modport slave (
    input  i_btn, i_sw,
    output o_tick, o_mode, o_color, o_dir, o_load
  );
endinterface

// File: rtl/led_seq_ctrl.sv
// LED sequencer controller: synchronises and debounces buttons/switches,
// runs the mode FSM, colour select and the rate-selectable step ticker.
module led_seq_ctrl #(
  parameter int NB_COUNT = 11,
  parameter int NB_SEL   = 2,
  parameter int NB_SW    = 4,
  parameter int DEB_LEN  = 4
) (
  input  logic          clock,
  input  logic          i_reset,
  led_seq_ctrl_if.slave bus
);

  localparam int                   NB_DEB   = $clog2(DEB_LEN);
  localparam logic [NB_DEB-1:0]    DEB_LAST = NB_DEB'(DEB_LEN - 1);
  localparam logic [NB_COUNT-1:0]  CNT_MAX  = '1;

  typedef enum logic [1:0] {
    MODE_SR    = 2'b00,
    MODE_FLASH = 2'b01,
    MODE_SR2   = 2'b10,
    MODE_BAD   = 2'b11
  } mode_t;

  logic [NB_SW-1:0]    btn_m, btn_s, sw_m, sw_s;
  logic [NB_SW-1:0]    btn_f, btn_f_q, press;
  logic [NB_DEB-1:0]   deb_cnt [NB_SW];
  logic [NB_COUNT-1:0] cnt_q, limit;
  logic [NB_SEL-1:0]   sel;
  logic                run_en, tick_q, load_q, mode_chg;
  logic [2:0]          color_q, color_d;
  mode_t               mode_q, mode_d;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      btn_m <= '0;
      btn_s <= '0;
      sw_m  <= '0;
      sw_s  <= '0;
    end else begin
      btn_m <= bus.i_btn;
      btn_s <= btn_m;
      sw_m  <= bus.i_sw;
      sw_s  <= sw_m;
    end
  end

  // Filtered level flips only after DEB_LEN consecutive mismatching edges.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      btn_f   <= '0;
      btn_f_q <= '0;
      for (int i = 0; i < NB_SW; i++) deb_cnt[i] <= '0;
    end else begin
      btn_f_q <= btn_f;
      for (int i = 0; i < NB_SW; i++) begin
        if (btn_s[i] == btn_f[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          btn_f[i]   <= btn_s[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + NB_DEB'(1);
        end
      end
    end
  end

  assign press = btn_f & ~btn_f_q;

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) mode_q <= MODE_SR;
    else          mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      MODE_SR:    if (press[0]) mode_d = MODE_FLASH;
      MODE_FLASH: if (press[0]) mode_d = MODE_SR2;
      MODE_SR2:   if (press[0]) mode_d = MODE_SR;
      default:    mode_d = MODE_SR;
    endcase
    mode_chg = (mode_d != mode_q);
  end

  // Red wins over green, green over blue when presses coincide.
  always_comb begin
    color_d = color_q;
    if      (press[1]) color_d = 3'b001;
    else if (press[2]) color_d = 3'b010;
    else if (press[3]) color_d = 3'b100;
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      color_q <= 3'b001;
      load_q  <= 1'b0;
    end else begin
      color_q <= color_d;
      load_q  <= mode_chg;
    end
  end

  assign run_en = sw_s[0];
  assign sel    = sw_s[NB_SEL:1];
  assign limit  = CNT_MAX >> {sel, 1'b0};

  // Compare with >= so shrinking the limit below the count wraps at once.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (mode_chg) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else if (!run_en) begin
      tick_q <= 1'b0;
    end else if (cnt_q >= limit) begin
      cnt_q  <= '0;
      tick_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_q + NB_COUNT'(1);
      tick_q <= 1'b0;
    end
  end

  assign bus.o_tick  = tick_q;
  assign bus.o_mode  = mode_q;
  assign bus.o_color = color_q;
  assign bus.o_dir   = sw_s[3];
  assign bus.o_load  = load_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Directed bench for led_seq_ctrl: reset values, debounce timing, mode/colour
// presses, tick period, run-enable/rate changes, mid-operation reset, o_dir.
module tb_led_seq_ctrl;

  logic clock;
  logic i_reset;
  int   compared;
  int   mismatched;
  int   n;
  int   ticks;

  led_seq_ctrl_if #(.NB_SW(4)) bus ();

  led_seq_ctrl #(
    .NB_COUNT(11),
    .NB_SEL  (2),
    .NB_SW   (4),
    .DEB_LEN (4)
  ) dut (
    .clock  (clock),
    .i_reset(i_reset),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Steps until o_tick is seen; returns edges taken, or -1 on timeout.
  task automatic wait_tick(input int max_cyc, output int edges);
    edges = 0;
    do begin
      step(1);
      edges++;
    end while (!bus.o_tick && edges < max_cyc);
    if (!bus.o_tick) edges = -1;
  endtask

  task automatic count_ticks(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      step(1);
      if (bus.o_tick) seen++;
    end
  endtask

  logic [1:0] mode_seq [3];
  logic [1:0] mode_prev;

  initial begin
    compared   = 0;
    mismatched = 0;
    mode_seq   = '{2'b01, 2'b10, 2'b00};

    // Reset state, then power-up tick timing at sel=3 (L=31)
    i_reset    = 1'b0;
    bus.i_btn  = 4'b0000;
    bus.i_sw   = 4'b0111;
    step(3);
    check("rst_mode", bus.o_mode, 2'b00);
    check("rst_color", bus.o_color, 3'b001);
    check("rst_tick", bus.o_tick, 1'b0);
    check("rst_load", bus.o_load, 1'b0);
    check("rst_dir", bus.o_dir, 1'b0);
    i_reset = 1'b1;
    wait_tick(60, n);
    check("first_tick", n, 34);
    step(1);
    check("tick_width", bus.o_tick, 1'b0);
    wait_tick(60, n);
    check("tick_period", n, 31);

    // Three mode presses: change on edge 7, one load pulse, tick phase restarts
    mode_prev = 2'b00;
    for (int p = 0; p < 3; p++) begin
      bus.i_btn = 4'b0001;
      step(6);
      check("mode_pre", bus.o_mode, mode_prev);
      check("load_pre", bus.o_load, 1'b0);
      step(1);
      check("mode_step", bus.o_mode, mode_seq[p]);
      check("load_pulse", bus.o_load, 1'b1);
      step(1);
      check("load_end", bus.o_load, 1'b0);
      wait_tick(40, n);
      check("tick_restart", n, 31);
      bus.i_btn = 4'b0000;
      step(12);
      check("mode_release", bus.o_mode, mode_seq[p]);
      mode_prev = mode_seq[p];
    end

    // Green glitch of 3 cycles is filtered; a real hold selects green
    bus.i_btn = 4'b0100;
    step(3);
    bus.i_btn = 4'b0000;
    step(12);
    check("glitch_color", bus.o_color, 3'b001);
    bus.i_btn = 4'b0100;
    step(6);
    check("green_pre", bus.o_color, 3'b001);
    step(1);
    check("green", bus.o_color, 3'b010);
    check("color_no_load", bus.o_load, 1'b0);
    bus.i_btn = 4'b0000;
    step(12);

    // Red+blue with mode press on the same edge
    bus.i_btn = 4'b1011;
    step(7);
    check("prio_color", bus.o_color, 3'b001);
    check("prio_mode", bus.o_mode, 2'b01);
    bus.i_btn = 4'b0000;
    step(12);

    // Run enable cleared 20 cycles mid-period
    wait_tick(40, n);
    check("sync_tick", (n > 0), 1'b1);
    step(10);
    bus.i_sw = 4'b0110;
    count_ticks(20, ticks);
    check("ticks_disabled", ticks, 0);
    bus.i_sw = 4'b0111;
    wait_tick(40, n);
    check("tick_resume", n, 22);

    // sel 3->0, run to count 100, then sel 0->3 wraps on the next edge
    bus.i_sw = 4'b0001;
    count_ticks(98, ticks);
    check("ticks_sel0", ticks, 0);
    bus.i_sw = 4'b0111;
    wait_tick(10, n);
    check("sel_wrap", n, 3);
    wait_tick(40, n);
    check("period_after_wrap", n, 32);

    // Reset mid-debounce and mid-period; held button presses after release
    bus.i_btn = 4'b0100;
    step(3);
    i_reset = 1'b0;
    #1;
    check("mid_rst_mode", bus.o_mode, 2'b00);
    check("mid_rst_color", bus.o_color, 3'b001);
    check("mid_rst_tick", bus.o_tick, 1'b0);
    check("mid_rst_load", bus.o_load, 1'b0);
    check("mid_rst_dir", bus.o_dir, 1'b0);
    step(3);
    i_reset = 1'b1;
    step(6);
    check("held_pre", bus.o_color, 3'b001);
    step(1);
    check("held_press", bus.o_color, 3'b010);
    wait_tick(40, n);
    check("post_rst_tick", n, 27);
    bus.i_btn = 4'b0000;

    // o_dir follows sw[3] with two cycles of latency
    bus.i_sw = 4'b1111;
    step(1);
    check("dir_lat1", bus.o_dir, 1'b0);
    step(1);
    check("dir_rise", bus.o_dir, 1'b1);
    bus.i_sw = 4'b0111;
    step(1);
    check("dir_hold", bus.o_dir, 1'b1);
    step(1);
    check("dir_fall", bus.o_dir, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
